dmem_responder: RTL

Data-memory responder serving the CPU's load/store path through a valid/ready request/response handshake.
- Replaces the zero-latency distributed RAM with a word-addressed, byte-enabled store.
- Supports configurable wait states and address-error signalling.
- Sits between the MEM pipeline stage (initiator) and on-chip data storage.
- One transaction outstanding at a time.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_if.sv | 34 +++
 rtl/dmem_byte_ram.sv | 36 +++
 rtl/dmem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmem_state_e      : responder FSM encoding (IDLE / WAIT / RESP)
//   - WORD_W / BYTE_W / LANES : data word and byte-lane geometry
//   - CNT_W             : width of the wait-state counter (0..15 wait states)
//   - DEFAULT_MMIO_BASE : default byte address of the cycle-counter register
//   - addr_in_range()   : true when a byte address falls inside DEPTH words
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = WORD_W / BYTE_W;
    localparam int CNT_W  = 4;

    localparam logic [WORD_W-1:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

    // A byte address is in range when it is below DEPTH*4. For a power-of-two
    // DEPTH this is the same as all address bits above the word index being 0.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                           input int unsigned       depth);
        logic [WORD_W+1:0] limit;
        limit = {2'b00, depth} << 2;
        return ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Request/response handshake bundle between the MEM stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_addr, req_wdata, req_be : request payload
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : response payload
// -----------------------------------------------------------------------------
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [LANES-1:0]  req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// -----------------------------------------------------------------------------
// dmem_byte_ram
// DEPTH x 32-bit storage with one write enable per byte lane.
// Synchronous write, combinational read; the array has no reset.
//   clk     : clock
//   idx     : word index for both write and read
//   wr_be   : byte-lane write enables (all zero = no write)
//   wr_data : write data
//   rd_data : combinational read data at idx
// -----------------------------------------------------------------------------
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [LANES-1:0]         wr_be,
    input  logic [WORD_W-1:0]        wr_data,
    output logic [WORD_W-1:0]        rd_data
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Byte-lane write into the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                mem_r[idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rd_data = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the CPU load/store path. Accepts one request at a
// time, waits WAIT_STATES cycles, commits the access on the edge entering RESP
// and holds the response until the initiator takes it.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous reset, active low
//   bus   : dmem_if.slave (req_* in, req_ready out, rsp_* out, rsp_ready in)
//
// Parameters:
//   DEPTH       : number of 32-bit words (power of two, >= 4)
//   WAIT_STATES : extra cycles between accept and response (0..15)
//   MMIO_BASE   : byte address of the cycle-counter register
//
// Optional feature macro: DMEM_MMIO_EN adds a free-running cycle counter
// readable at MMIO_BASE. Without it, MMIO_BASE is an ordinary out-of-range
// address.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                DEPTH       = 64,
    parameter int                WAIT_STATES = 0,
    parameter logic [WORD_W-1:0] MMIO_BASE   = DEFAULT_MMIO_BASE
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);

    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    dmem_state_e       state_r;
    dmem_state_e       next_state_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              we_r;
    logic [WORD_W-1:0] addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic [LANES-1:0]  be_r;
    logic              rsp_valid_r;
    logic [WORD_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    logic              accept_s;
    logic              commit_s;
    logic              misalign_s;
    logic              mmio_hit_s;
    logic              addr_err_s;
    logic [LANES-1:0]  ram_be_s;
    logic [WORD_W-1:0] ram_rdata_s;
    logic [WORD_W-1:0] load_data_s;

    assign accept_s = (state_r == ST_IDLE) && bus.req_valid;
    // The access takes effect only on the edge leaving WAIT; a reset on that
    // edge drops it, including the RAM write.
    assign commit_s = (state_r == ST_WAIT) && (wait_cnt_r == {CNT_W{1'b0}}) && reset;

`ifdef DMEM_MMIO_EN
    logic [WORD_W-1:0] cycle_cnt_r;

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_r <= {WORD_W{1'b0}};
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
    end
`else
    // No counter in this build; MMIO_BASE is only kept referenced.
    logic unused_mmio_base_s;
    assign unused_mmio_base_s = ^MMIO_BASE;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter is loaded with WAIT_STATES and WAIT always lasts at
                // least one cycle, so the response appears WAIT_STATES+1
                // cycles after the accept edge.
                if (wait_cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Address decode, RAM write enables and load-data selection
    always_comb begin
        misalign_s  = 1'b0;
        mmio_hit_s  = 1'b0;
        addr_err_s  = 1'b0;
        ram_be_s    = {LANES{1'b0}};
        load_data_s = {WORD_W{1'b0}};

        misalign_s = (addr_r[1:0] != 2'b00);
`ifdef DMEM_MMIO_EN
        mmio_hit_s = (addr_r == MMIO_BASE);
`else
        mmio_hit_s = 1'b0;
`endif
        addr_err_s = misalign_s || (!addr_in_range(addr_r, DEPTH) && !mmio_hit_s);

        // Stores to MMIO or to a bad address never reach the array.
        if (commit_s && we_r && !addr_err_s && !mmio_hit_s) begin
            ram_be_s = be_r;
        end else begin
            ram_be_s = {LANES{1'b0}};
        end

        if (!we_r && !addr_err_s) begin
`ifdef DMEM_MMIO_EN
            if (mmio_hit_s) begin
                load_data_s = cycle_cnt_r;
            end else begin
                load_data_s = ram_rdata_s;
            end
`else
            load_data_s = ram_rdata_s;
`endif
        end else begin
            load_data_s = {WORD_W{1'b0}};
        end
    end

    // Request latch, wait-state counter and registered response
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_r  <= {CNT_W{1'b0}};
            we_r        <= 1'b0;
            addr_r      <= {WORD_W{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            be_r        <= {LANES{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WORD_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r       <= bus.req_we;
                addr_r     <= bus.req_addr;
                wdata_r    <= bus.req_wdata;
                be_r       <= bus.req_be;
                wait_cnt_r <= WAIT_INIT;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != {CNT_W{1'b0}})) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end

            if (commit_s) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= load_data_s;
                rsp_err_r   <= addr_err_s;
            end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    dmem_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .idx     (addr_r[IDX_W+1:2]),
        .wr_be   (ram_be_s),
        .wr_data (wdata_r),
        .rd_data (ram_rdata_s)
    );

    // req_ready is forced low for as long as reset is held.
    assign bus.req_ready = (state_r == ST_IDLE) && reset;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule
